// File: rtl/icap_stream_ctrl_if.sv
// rtl/icap_stream_ctrl_if.sv - UART byte input, ICAP write port and frame status bundle
interface icap_stream_ctrl_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        icap_csib;
  logic        icap_rdwrb;
  logic [31:0] icap_data;
  logic        busy;
  logic        programming_done;
  logic        error;
  logic [31:0] words_written;

  modport master (
    output rx_data, rx_valid,
    input  icap_csib, icap_rdwrb, icap_data, busy, programming_done, error, words_written
  );

  modport slave (
    input  rx_data, rx_valid,
    output icap_csib, icap_rdwrb, icap_data, busy, programming_done, error, words_written
  );
endinterface

// File: rtl/icap_stream_ctrl.sv
// rtl/icap_stream_ctrl.sv - framed UART bitstream to ICAP sequencer; ICAP_BITSWAP_EN reverses bits in each icap_data byte lane
module icap_stream_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_WORDS      = 4194304
) (
  input logic               clk,
  input logic               rst,
  icap_stream_ctrl_if.slave bus
);
  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]   MAX_N    = 32'(MAX_WORDS);
  localparam logic [7:0]    HDR      = 8'hA5;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DONE, S_ERROR} state_t;

  state_t        state;
  logic [1:0]    byte_cnt;
  logic [23:0]   word_sr;
  logic [31:0]   n_words;
  logic [31:0]   words_written;
  logic [31:0]   icap_word;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;
  logic          icap_csib;
  logic          icap_rdwrb;
  logic          busy;
  logic          programming_done;
  logic          error;

  logic        frame_open;
  logic        tmo_hit;
  logic        start;
  logic [31:0] n_next;
  logic [31:0] word_next;
  logic [31:0] ww_next;

  assign frame_open = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  // A byte arriving on the expiry cycle takes priority over the timeout
  assign tmo_hit    = frame_open && !bus.rx_valid && (tmo_cnt == TMO_LAST);
  assign start      = bus.rx_valid && (bus.rx_data == HDR);
  assign n_next     = {n_words[23:0], bus.rx_data};
  assign word_next  = {word_sr, bus.rx_data};
  assign ww_next    = words_written + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      byte_cnt         <= '0;
      word_sr          <= '0;
      n_words          <= '0;
      words_written    <= '0;
      icap_word        <= '0;
      csum             <= '0;
      tmo_cnt          <= '0;
      icap_csib        <= 1'b1;
      icap_rdwrb       <= 1'b1;
      busy             <= 1'b0;
      programming_done <= 1'b0;
      error            <= 1'b0;
    end else begin
      icap_csib <= 1'b1;
      if (!frame_open || bus.rx_valid) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + 1'b1;

      if (tmo_hit) begin
        state      <= S_ERROR;
        busy       <= 1'b0;
        error      <= 1'b1;
        icap_rdwrb <= 1'b1;
      end else begin
        case (state)
          S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
              state            <= S_LEN;
              busy             <= 1'b1;
              byte_cnt         <= '0;
              csum             <= HDR;  // header byte is folded into the checksum
              words_written    <= '0;
              programming_done <= 1'b0;
              error            <= 1'b0;
              icap_rdwrb       <= 1'b0;
            end
          end
          S_LEN: begin
            if (bus.rx_valid) begin
              n_words  <= n_next;
              csum     <= csum ^ bus.rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (n_next == 32'd0 || n_next > MAX_N) begin
                  state      <= S_ERROR;
                  busy       <= 1'b0;
                  error      <= 1'b1;
                  icap_rdwrb <= 1'b1;
                end else begin
                  state <= S_PAYLOAD;
                end
              end
            end
          end
          S_PAYLOAD: begin
            if (bus.rx_valid) begin
              word_sr  <= word_next[23:0];
              csum     <= csum ^ bus.rx_data;
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                icap_csib     <= 1'b0;
                icap_word     <= word_next;
                words_written <= ww_next;
                if (ww_next == n_words) state <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (bus.rx_valid) begin
              busy       <= 1'b0;
              icap_rdwrb <= 1'b1;
              if (bus.rx_data == csum) begin
                state            <= S_DONE;
                programming_done <= 1'b1;
              end else begin
                state <= S_ERROR;
                error <= 1'b1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ICAP_BITSWAP_EN
  logic [31:0] icap_swapped;
  always_comb begin
    icap_swapped = '0;
    for (int lane = 0; lane < 4; lane++)
      for (int b = 0; b < 8; b++)
        icap_swapped[lane*8 + b] = icap_word[lane*8 + 7 - b];
  end
  assign bus.icap_data = icap_swapped;
`else
  assign bus.icap_data = icap_word;
`endif

  assign bus.icap_csib        = icap_csib;
  assign bus.icap_rdwrb       = icap_rdwrb;
  assign bus.busy             = busy;
  assign bus.programming_done = programming_done;
  assign bus.error            = error;
  assign bus.words_written    = words_written;
endmodule

// File: tb/tb_icap_stream_ctrl.sv
// tb/tb_icap_stream_ctrl.sv - directed-vector bench for icap_stream_ctrl
module tb_icap_stream_ctrl;
`ifdef ICAP_BITSWAP_EN
  localparam logic [31:0] W0 = 32'h5599AA66;
  localparam logic [31:0] W1 = 32'h04000000;
  localparam logic [31:0] W2 = 32'h482C6A1E;
  localparam logic [31:0] W3 = 32'h7BB57DF7;
`else
  localparam logic [31:0] W0 = 32'hAA995566;
  localparam logic [31:0] W1 = 32'h20000000;
  localparam logic [31:0] W2 = 32'h12345678;
  localparam logic [31:0] W3 = 32'hDEADBEEF;
`endif

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   strobes;
  int   base;
  logic [31:0] strobe_data[$];

  icap_stream_ctrl_if bus();

  icap_stream_ctrl #(.TIMEOUT_CYCLES(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst && bus.icap_csib === 1'b0) begin
      strobes++;
      strobe_data.push_back(bus.icap_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n);
    for (int i = 3; i >= 0; i--) send_byte(n[i*8 +: 8]);
  endtask

  task automatic send_good_body(input logic [7:0] cs);
    logic [7:0] pl [8];
    pl = '{8'hAA, 8'h99, 8'h55, 8'h66, 8'h20, 8'h00, 8'h00, 8'h00};
    send_len(32'd2);
    for (int i = 0; i < 8; i++) send_byte(pl[i]);
    send_byte(cs);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_csib"},  32'(bus.icap_csib), 32'd1);
    check({tag, "_rdwrb"}, 32'(bus.icap_rdwrb), 32'd1);
    check({tag, "_data"},  bus.icap_data, 32'd0);
    check({tag, "_busy"},  32'(bus.busy), 32'd0);
    check({tag, "_done"},  32'(bus.programming_done), 32'd0);
    check({tag, "_err"},   32'(bus.error), 32'd0);
    check({tag, "_ww"},    bus.words_written, 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    strobes = 0;
    rst = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);

    send_byte(8'h3C);
    check("idle_ignore_busy", 32'(bus.busy), 32'd0);

    // good frame
    base = strobes;
    send_byte(8'hA5);
    check("hdr_busy", 32'(bus.busy), 32'd1);
    check("hdr_rdwrb", 32'(bus.icap_rdwrb), 32'd0);
    send_good_body(8'h87);
    check("good_strobes", 32'(strobes - base), 32'd2);
    check("good_w0", strobe_data[base], W0);
    check("good_w1", strobe_data[base + 1], W1);
    check("good_done", 32'(bus.programming_done), 32'd1);
    check("good_err", 32'(bus.error), 32'd0);
    check("good_ww", bus.words_written, 32'd2);
    check("good_busy", 32'(bus.busy), 32'd0);
    check("good_rdwrb", 32'(bus.icap_rdwrb), 32'd1);
    check("good_data_hold", bus.icap_data, W1);

    // bad checksum
    base = strobes;
    send_byte(8'hA5);
    check("restart_done_clr", 32'(bus.programming_done), 32'd0);
    send_good_body(8'h00);
    check("badcs_strobes", 32'(strobes - base), 32'd2);
    check("badcs_err", 32'(bus.error), 32'd1);
    check("badcs_done", 32'(bus.programming_done), 32'd0);
    check("badcs_ww", bus.words_written, 32'd2);

    // zero length
    base = strobes;
    send_byte(8'hA5);
    check("zero_err_clr", 32'(bus.error), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    check("zero_err_early", 32'(bus.error), 32'd0);
    send_byte(8'h00);
    check("zero_err", 32'(bus.error), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);
    check("zero_strobes", 32'(strobes - base), 32'd0);

    // length just above the maximum
    send_byte(8'hA5);
    send_len(32'd4194305);
    check("toolong_err", 32'(bus.error), 32'd1);

    // timeout after one payload byte
    base = strobes;
    send_byte(8'hA5);
    send_len(32'd1);
    send_byte(8'hAA);
    repeat (49) @(negedge clk);
    check("tmo_err_49", 32'(bus.error), 32'd0);
    check("tmo_busy_49", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("tmo_err_50", 32'(bus.error), 32'd1);
    check("tmo_busy_50", 32'(bus.busy), 32'd0);
    check("tmo_rdwrb", 32'(bus.icap_rdwrb), 32'd1);
    check("tmo_strobes", 32'(strobes - base), 32'd0);

    // byte on the expiry cycle wins
    send_byte(8'hA5);
    send_len(32'd1);
    repeat (49) @(negedge clk);
    send_byte(8'h12);
    check("race_err", 32'(bus.error), 32'd0);
    check("race_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    check("race_csib", 32'(bus.icap_csib), 32'd0);
    check("race_data", bus.icap_data, W2);
    @(negedge clk);
    send_byte(8'hAC);
    check("race_done", 32'(bus.programming_done), 32'd1);

    // back-to-back payload bytes
    send_byte(8'hA5);
    send_len(32'd1);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("b2b_csib", 32'(bus.icap_csib), 32'd0);
    check("b2b_data", bus.icap_data, W3);
    check("b2b_ww", bus.words_written, 32'd1);
    @(negedge clk);
    check("b2b_csib_off", 32'(bus.icap_csib), 32'd1);
    check("b2b_data_hold", bus.icap_data, W3);
    send_byte(8'h86);
    check("b2b_done", 32'(bus.programming_done), 32'd1);

    // async reset mid-payload, then a clean frame
    send_byte(8'hA5);
    send_len(32'd2);
    send_byte(8'h11); send_byte(8'h22);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base = strobes;
    send_byte(8'hA5);
    send_good_body(8'h87);
    check("postrst_done", 32'(bus.programming_done), 32'd1);
    check("postrst_ww", bus.words_written, 32'd2);
    check("postrst_w0", strobe_data[base], W0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
